// File: rtl/xeng_corr_apply_pkg.sv
// Shared constants, lane map and state type for the uint-offset correction apply stage.
// Derived sizes are computed by helper functions so the top can re-derive them from its own parameters.
package xeng_corr_apply_pkg;

  localparam int SERIAL_ACC_LEN_BITS_DEF = 7;
  localparam int P_FACTOR_BITS_DEF       = 2;
  localparam int BITWIDTH_DEF            = 4;
  localparam int N_ANTS_DEF              = 32;
  localparam int ACC_WIDTH_DEF           = 24;
  localparam int FIFO_DEPTH_BITS_DEF     = 5;

  localparam int N_LANES    = 8;
  localparam int LANE_RE_XX = 0;
  localparam int LANE_RE_XY = 1;
  localparam int LANE_RE_YX = 2;
  localparam int LANE_RE_YY = 3;
  localparam int LANE_IM_XX = 4;
  localparam int LANE_IM_XY = 5;
  localparam int LANE_IM_YX = 6;
  localparam int LANE_IM_YY = 7;

  function automatic int calcCorrWidth(input int pFactorBits, input int serialAccBits, input int bitWidth);
    return pFactorBits + serialAccBits + bitWidth + 3;
  endfunction

  function automatic int calcNTaps(input int nAnts);
    return nAnts / 2 + 1;
  endfunction

  function automatic int calcNBl(input int nAnts);
    return nAnts * calcNTaps(nAnts);
  endfunction

  // The correction is counted in units of the sample offset 2^(BITWIDTH-1).
  function automatic int calcOffsetShift(input int bitWidth);
    return bitWidth - 1;
  endfunction

  localparam int CORR_WIDTH   = calcCorrWidth(P_FACTOR_BITS_DEF, SERIAL_ACC_LEN_BITS_DEF, BITWIDTH_DEF);
  localparam int N_TAPS       = calcNTaps(N_ANTS_DEF);
  localparam int N_BL         = calcNBl(N_ANTS_DEF);
  localparam int OFFSET_SHIFT = calcOffsetShift(BITWIDTH_DEF);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } corr_state_e;

endpackage

// File: rtl/xeng_corr_apply_corr_fifo.sv
// Single-clock correction FIFO with registered read data; a flush empties it before any same-cycle push/pop.
// full/empty describe the post-flush state so callers can judge the current cycle's push and pop.
module corr_fifo
  import xeng_corr_apply_pkg::*;
#(
  parameter int WIDTH      = N_LANES * CORR_WIDTH,
  parameter int DEPTH_BITS = FIFO_DEPTH_BITS_DEF
)(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [WIDTH-1:0]      i_wdata,
  output logic [WIDTH-1:0]      o_rdata,
  output logic [DEPTH_BITS:0]   o_level,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FULL_LEVEL = (DEPTH_BITS + 1)'(DEPTH);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [WIDTH-1:0]      r_rdata;
  logic [DEPTH_BITS-1:0] r_wrPtr;
  logic [DEPTH_BITS-1:0] r_rdPtr;
  logic [DEPTH_BITS-1:0] w_rdBase;
  logic [DEPTH_BITS:0]   r_level;
  logic [DEPTH_BITS:0]   w_levelBase;
  logic                  w_doPush;
  logic                  w_doPop;

  // Flushing moves the read pointer onto the write pointer instead of resetting both.
  assign w_levelBase = i_flush ? '0 : r_level;
  assign w_rdBase    = i_flush ? r_wrPtr : r_rdPtr;
  assign o_empty     = (w_levelBase == '0);
  assign o_full      = (w_levelBase == FULL_LEVEL);
  assign w_doPop     = i_pop & ~o_empty;
  assign w_doPush    = i_push & (~o_full | w_doPop);

  always_ff @(posedge i_clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
      r_rdata <= '0;
    end else begin
      r_wrPtr <= r_wrPtr + DEPTH_BITS'(w_doPush);
      r_rdPtr <= w_rdBase + DEPTH_BITS'(w_doPop);
      r_level <= w_levelBase + (DEPTH_BITS + 1)'(w_doPush) - (DEPTH_BITS + 1)'(w_doPop);
      if (i_pop) begin
        r_rdata <= w_doPop ? r_mem[w_rdBase] : '0;
      end
    end
  end

  assign o_rdata = r_rdata;
  assign o_level = r_level;

endmodule

// File: rtl/xeng_corr_apply.sv
// Subtracts buffered per-baseline offset corrections from X-engine accumulator words.
// Two-stage pipeline: stage 1 holds din plus the popped correction, stage 2 holds the corrected word.
module xeng_corr_apply
  import xeng_corr_apply_pkg::*;
#(
  parameter int SERIAL_ACC_LEN_BITS = SERIAL_ACC_LEN_BITS_DEF,
  parameter int P_FACTOR_BITS       = P_FACTOR_BITS_DEF,
  parameter int BITWIDTH            = BITWIDTH_DEF,
  parameter int N_ANTS              = N_ANTS_DEF,
  parameter int ACC_WIDTH           = ACC_WIDTH_DEF,
  parameter int FIFO_DEPTH_BITS     = FIFO_DEPTH_BITS_DEF,
  localparam int CORR_W             = calcCorrWidth(P_FACTOR_BITS, SERIAL_ACC_LEN_BITS, BITWIDTH)
)(
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_sync,
  input  logic                         i_corr_vld,
  input  logic [N_LANES*CORR_W-1:0]    i_corr_in,
  input  logic                         i_din_vld,
  input  logic [N_LANES*ACC_WIDTH-1:0] i_din,
  output logic                         o_dout_vld,
  output logic [N_LANES*ACC_WIDTH-1:0] o_dout,
  output logic                         o_sync_out,
  output logic                         o_win_done,
  output logic [FIFO_DEPTH_BITS:0]     o_fifo_level,
  output logic                         o_err_underflow,
  output logic                         o_err_overflow
);

  localparam int NUM_BL    = calcNBl(N_ANTS);
  localparam int OFF_SHIFT = calcOffsetShift(BITWIDTH);
  localparam int CNT_W     = $clog2(NUM_BL);

  corr_state_e                  r_state;
  logic [CNT_W-1:0]             r_blCount;
  logic [CNT_W-1:0]             w_cntBase;
  logic                         w_cntLast;
  logic                         w_active;
  logic                         w_push;
  logic                         w_pop;
  logic                         w_fifoFull;
  logic                         w_fifoEmpty;
  logic [N_LANES*CORR_W-1:0]    w_corrRd;
  logic [N_LANES*ACC_WIDTH-1:0] r_s1Din;
  logic                         r_s1Vld;
  logic                         r_s1Last;
  logic [N_LANES*ACC_WIDTH-1:0] w_diff;
  logic [N_LANES*ACC_WIDTH-1:0] r_dout;
  logic                         r_doutVld;
  logic                         r_winDone;
  logic                         r_syncD1;
  logic                         r_syncOut;
  logic                         r_errUnder;
  logic                         r_errOver;

  // A sync seen in IDLE already counts as RUN, so its same-cycle words are processed.
  assign w_active  = (r_state == ST_RUN) | i_sync;
  assign w_push    = i_corr_vld & w_active;
  assign w_pop     = i_din_vld & w_active;
  assign w_cntBase = i_sync ? '0 : r_blCount;
  assign w_cntLast = (w_cntBase == CNT_W'(NUM_BL - 1));

  corr_fifo #(
    .WIDTH      (N_LANES * CORR_W),
    .DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_sync),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (i_corr_in),
    .o_rdata (w_corrRd),
    .o_level (o_fifo_level),
    .o_full  (w_fifoFull),
    .o_empty (w_fifoEmpty)
  );

  // Working modulo 2^ACC_WIDTH gives the same bits as a wider subtract followed by truncation.
  for (genvar l = LANE_RE_XX; l <= LANE_IM_YY; l++) begin : g_lane
    localparam int A_LSB = (N_LANES - 1 - l) * ACC_WIDTH;
    localparam int C_LSB = (N_LANES - 1 - l) * CORR_W;
    logic [ACC_WIDTH-1:0] w_corrScaled;
    assign w_corrScaled = {{(ACC_WIDTH - CORR_W){w_corrRd[C_LSB+CORR_W-1]}},
                           w_corrRd[C_LSB +: CORR_W]} << OFF_SHIFT;
    assign w_diff[A_LSB +: ACC_WIDTH] = r_s1Din[A_LSB +: ACC_WIDTH] - w_corrScaled;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_blCount  <= '0;
      r_s1Din    <= '0;
      r_s1Vld    <= 1'b0;
      r_s1Last   <= 1'b0;
      r_dout     <= '0;
      r_doutVld  <= 1'b0;
      r_winDone  <= 1'b0;
      r_syncD1   <= 1'b0;
      r_syncOut  <= 1'b0;
      r_errUnder <= 1'b0;
      r_errOver  <= 1'b0;
    end else begin
      if (i_sync) begin
        r_state <= ST_RUN;
      end
      r_blCount <= w_pop ? (w_cntLast ? '0 : w_cntBase + CNT_W'(1)) : w_cntBase;
      r_s1Vld   <= w_pop;
      r_s1Last  <= w_pop & w_cntLast;
      if (w_pop) begin
        r_s1Din <= i_din;
      end
      r_doutVld <= r_s1Vld;
      r_winDone <= r_s1Vld & r_s1Last;
      if (r_s1Vld) begin
        r_dout <= w_diff;
      end
      r_syncD1  <= i_sync;
      r_syncOut <= r_syncD1;
      // Sync clears the sticky flags, but an error in the same cycle still lands.
      r_errUnder <= (r_errUnder & ~i_sync) | (w_pop & w_fifoEmpty);
      r_errOver  <= (r_errOver & ~i_sync) | (w_push & w_fifoFull & ~w_pop);
    end
  end

  assign o_dout_vld      = r_doutVld;
  assign o_dout          = r_dout;
  assign o_win_done      = r_winDone;
  assign o_sync_out      = r_syncOut;
  assign o_err_underflow = r_errUnder;
  assign o_err_overflow  = r_errOver;

endmodule

// File: tb/tb_xeng_corr_apply.sv
// Bench for xeng_corr_apply: a directed vector table, hand-written overflow/window sequences,
// and random traffic compared against a queue-based reference model.
module tb_xeng_corr_apply;

  localparam int ACC_W   = 24;
  localparam int CORR_W  = 16;
  localparam int NBL     = 544;
  localparam int DEPTH   = 32;
  localparam int SHIFT   = 3;

  logic         clk;
  logic         rst;
  logic         sync;
  logic         corrVld;
  logic [127:0] corrIn;
  logic         dinVld;
  logic [191:0] din;
  logic         doutVld;
  logic [191:0] dout;
  logic         syncOut;
  logic         winDone;
  logic [5:0]   fifoLevel;
  logic         errU;
  logic         errO;

  int checks = 0;
  int errors = 0;

  xeng_corr_apply dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_sync          (sync),
    .i_corr_vld      (corrVld),
    .i_corr_in       (corrIn),
    .i_din_vld       (dinVld),
    .i_din           (din),
    .o_dout_vld      (doutVld),
    .o_dout          (dout),
    .o_sync_out      (syncOut),
    .o_win_done      (winDone),
    .o_fifo_level    (fifoLevel),
    .o_err_underflow (errU),
    .o_err_overflow  (errO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           vld;
    logic [191:0] dout;
    bit           win;
    bit           sync;
  } pipe_t;

  logic [127:0] mQ[$];
  bit           mRun;
  bit           mErrU;
  bit           mErrO;
  int           mCnt;
  pipe_t        mPend;
  pipe_t        mExp;
  logic [191:0] mDoutHeld;

  typedef struct {
    bit          sync;
    bit          cv;
    logic [15:0] cLane;
    bit          dv;
    logic [23:0] dLane;
    bit          eVld;
    logic [23:0] eDout;
    bit          eSync;
    int          eLevel;
    bit          eErrU;
    bit          eErrO;
  } vec_t;

  vec_t vecs[$];

  // Reference: each lane is din minus corr times the sample offset, wrapped to 24 bits.
  function automatic logic [191:0] refCorrect(input logic [191:0] d, input logic [127:0] c);
    logic [191:0] res;
    longint dv;
    longint cv;
    longint r;
    for (int l = 0; l < 8; l++) begin
      dv = longint'($signed(d[l*ACC_W +: ACC_W]));
      cv = longint'($signed(c[l*CORR_W +: CORR_W]));
      r  = dv - cv * (longint'(1) << SHIFT);
      res[l*ACC_W +: ACC_W] = r[23:0];
    end
    return res;
  endfunction

  task automatic modelReset();
    mQ.delete();
    mRun      = 1'b0;
    mErrU     = 1'b0;
    mErrO     = 1'b0;
    mCnt      = 0;
    mPend     = '{vld: 1'b0, dout: '0, win: 1'b0, sync: 1'b0};
    mExp      = mPend;
    mDoutHeld = '0;
  endtask

  task automatic modelStep(input bit s, input bit cv, input logic [127:0] c,
                           input bit dv, input logic [191:0] d);
    pipe_t n;
    logic [127:0] corr;
    bit active;
    n = '{vld: 1'b0, dout: '0, win: 1'b0, sync: s};
    active = mRun || s;
    if (s) begin
      mQ.delete();
      mErrU = 1'b0;
      mErrO = 1'b0;
      mCnt  = 0;
      mRun  = 1'b1;
    end
    if (active) begin
      if (dv) begin
        corr = '0;
        if (mQ.size() == 0) mErrU = 1'b1;
        else corr = mQ.pop_front();
        n.vld  = 1'b1;
        n.dout = refCorrect(d, corr);
        n.win  = (mCnt == NBL - 1);
        mCnt   = (mCnt + 1) % NBL;
      end
      if (cv) begin
        if (mQ.size() < DEPTH) mQ.push_back(c);
        else mErrO = 1'b1;
      end
    end
    mExp  = mPend;
    mPend = n;
    if (mExp.vld) mDoutHeld = mExp.dout;
  endtask

  task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compareModel(input string tag);
    checkOutput({tag, "_dout_vld"}, doutVld, mExp.vld);
    checkOutput({tag, "_dout"}, dout, mDoutHeld);
    checkOutput({tag, "_win_done"}, winDone, mExp.win);
    checkOutput({tag, "_sync_out"}, syncOut, mExp.sync);
    checkOutput({tag, "_fifo_level"}, fifoLevel, mQ.size());
    checkOutput({tag, "_err_underflow"}, errU, mErrU);
    checkOutput({tag, "_err_overflow"}, errO, mErrO);
  endtask

  task automatic applyStimulus(input bit s, input bit cv, input logic [127:0] c,
                               input bit dv, input logic [191:0] d, input bit chk, input string tag);
    sync    = s;
    corrVld = cv;
    corrIn  = c;
    dinVld  = dv;
    din     = d;
    @(posedge clk);
    modelStep(s, cv, c, dv, d);
    #1;
    if (chk) compareModel(tag);
  endtask

  task automatic addVec(input bit s, input bit cv, input logic [15:0] c, input bit dv, input logic [23:0] d,
                        input bit eVld, input logic [23:0] eDout, input bit eSync, input int eLevel,
                        input bit eErrU, input bit eErrO);
    vecs.push_back('{sync: s, cv: cv, cLane: c, dv: dv, dLane: d, eVld: eVld, eDout: eDout,
                     eSync: eSync, eLevel: eLevel, eErrU: eErrU, eErrO: eErrO});
  endtask

  function automatic logic [191:0] randDin();
    logic [191:0] v;
    v = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    if ($urandom_range(0, 7) == 0) v = {8{24'h800000}};
    return v;
  endfunction

  function automatic logic [127:0] randCorr();
    logic [127:0] v;
    v = {$urandom(), $urandom(), $urandom(), $urandom()};
    if ($urandom_range(0, 7) == 0) v = {8{16'h7FFF}};
    return v;
  endfunction

  task automatic runWindow(input bit preSync, input string tag);
    int pulses;
    int vldIdx;
    int pulseAt;
    pulses  = 0;
    vldIdx  = 0;
    pulseAt = 0;
    applyStimulus(preSync, 1'b1, randCorr(), 1'b0, '0, 1'b1, tag);
    for (int i = 0; i < NBL + 3; i++) begin
      if (i < NBL - 1) applyStimulus(1'b0, 1'b1, randCorr(), 1'b1, randDin(), 1'b1, tag);
      else if (i == NBL - 1) applyStimulus(1'b0, 1'b0, '0, 1'b1, randDin(), 1'b1, tag);
      else applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, tag);
      if (doutVld) vldIdx++;
      if (winDone) begin
        pulses++;
        pulseAt = vldIdx;
      end
    end
    checkOutput({tag, "_pulse_count"}, pulses, 1);
    checkOutput({tag, "_pulse_index"}, pulseAt, NBL);
  endtask

  initial begin
    rst     = 1'b1;
    sync    = 1'b0;
    corrVld = 1'b0;
    corrIn  = '0;
    dinVld  = 1'b0;
    din     = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_dout_vld", doutVld, 0);
    checkOutput("reset_dout", dout, 0);
    checkOutput("reset_fifo_level", fifoLevel, 0);
    checkOutput("reset_errs", {errU, errO}, 0);
    checkOutput("reset_sync_win", {syncOut, winDone}, 0);
    rst = 1'b0;

    // sync cv c dv d | vld dout syncOut level errU errO
    addVec(0, 1, 16'd5,    1, 24'd100,     0, 24'h000000, 0, 0, 0, 0);
    addVec(0, 0, 16'd0,    0, 24'd0,       0, 24'h000000, 0, 0, 0, 0);
    addVec(1, 0, 16'd0,    0, 24'd0,       0, 24'h000000, 0, 0, 0, 0);
    addVec(0, 1, 16'd5,    0, 24'd0,       0, 24'h000000, 1, 1, 0, 0);
    addVec(0, 0, 16'd0,    0, 24'd0,       0, 24'h000000, 0, 1, 0, 0);
    addVec(0, 0, 16'd0,    1, 24'd100,     0, 24'h000000, 0, 0, 0, 0);
    addVec(0, 0, 16'd0,    0, 24'd0,       1, 24'd60,     0, 0, 0, 0);
    addVec(0, 0, 16'd0,    0, 24'd0,       0, 24'd60,     0, 0, 0, 0);
    addVec(0, 1, 16'hFFFF, 0, 24'd0,       0, 24'd60,     0, 1, 0, 0);
    addVec(0, 0, 16'd0,    1, 24'h800000,  0, 24'd60,     0, 0, 0, 0);
    addVec(0, 0, 16'd0,    0, 24'd0,       1, 24'h800008, 0, 0, 0, 0);
    addVec(0, 0, 16'd0,    1, 24'h000123,  0, 24'h800008, 0, 0, 1, 0);
    addVec(0, 0, 16'd0,    0, 24'd0,       1, 24'h000123, 0, 0, 1, 0);
    addVec(1, 0, 16'd0,    0, 24'd0,       0, 24'h000123, 0, 0, 0, 0);
    addVec(0, 0, 16'd0,    0, 24'd0,       0, 24'h000123, 1, 0, 0, 0);
    addVec(0, 1, 16'd1,    0, 24'd0,       0, 24'h000123, 0, 1, 0, 0);
    addVec(0, 0, 16'd0,    1, 24'h800000,  0, 24'h000123, 0, 0, 0, 0);
    addVec(0, 0, 16'd0,    0, 24'd0,       1, 24'h7FFFF8, 0, 0, 0, 0);
    addVec(1, 1, 16'd2,    1, 24'd10,      0, 24'h7FFFF8, 0, 1, 1, 0);
    addVec(0, 0, 16'd0,    0, 24'd0,       1, 24'h00000A, 1, 1, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].sync, vecs[i].cv, {8{vecs[i].cLane}}, vecs[i].dv, {8{vecs[i].dLane}},
                    1'b0, "vec");
      checkOutput($sformatf("vec%0d_dout_vld", i), doutVld, vecs[i].eVld);
      checkOutput($sformatf("vec%0d_dout", i), dout, {8{vecs[i].eDout}});
      checkOutput($sformatf("vec%0d_sync_out", i), syncOut, vecs[i].eSync);
      checkOutput($sformatf("vec%0d_fifo_level", i), fifoLevel, vecs[i].eLevel);
      checkOutput($sformatf("vec%0d_err_underflow", i), errU, vecs[i].eErrU);
      checkOutput($sformatf("vec%0d_err_overflow", i), errO, vecs[i].eErrO);
    end

    // Overflow: fill to depth, push+pop while full, then a dropped push, then drain.
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, "ovf");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, randCorr(), 1'b0, '0, 1'b1, "ovf");
    checkOutput("ovf_level_full", fifoLevel, DEPTH);
    checkOutput("ovf_no_err_yet", errO, 0);
    applyStimulus(1'b0, 1'b1, randCorr(), 1'b1, randDin(), 1'b1, "ovf");
    checkOutput("ovf_pushpop_level", fifoLevel, DEPTH);
    checkOutput("ovf_pushpop_no_err", errO, 0);
    applyStimulus(1'b0, 1'b1, randCorr(), 1'b0, '0, 1'b1, "ovf");
    checkOutput("ovf_drop_level", fifoLevel, DEPTH);
    checkOutput("ovf_drop_err", errO, 1);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1, randDin(), 1'b1, "drain");
    repeat (3) applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, "drain");

    runWindow(1'b1, "win1");
    runWindow(1'b0, "win2");

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        sync    = 1'b0;
        corrVld = 1'b0;
        dinVld  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_outputs", {doutVld, syncOut, winDone, errU, errO}, 0);
        checkOutput("midrst_dout", dout, 0);
        checkOutput("midrst_level", fifoLevel, 0);
        modelReset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, randCorr(), 1'b1, randDin(), 1'b1, "idle_ignore");
        applyStimulus(1'b1, 1'b1, randCorr(), 1'b1, randDin(), 1'b1, "idle_sync");
      end else begin
        applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, randCorr(),
                      $urandom_range(0, 1) == 1, randDin(), 1'b1, "rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
